// File: rtl/mem_access_unit.sv
// Data-memory access unit: turns a decoded load/store into one word-aligned
// req/ack bus transaction and returns the extended load result.
module mem_access_unit #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mem_op,
    input  logic [2:0]        mem_sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

    state_t            state_q, state_d;
    logic              st_q, st_d;
    logic [2:0]        sel_q, sel_d;
    logic [1:0]        off_q, off_d;
    logic              err_q, err_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [3:0]        strb_q, strb_d;

    logic              is_acc, sel_ok, align_ok;
    logic [31:0]       rd_shift;
    logic [15:0]       rd_half;

    always_comb begin
        is_acc = (mem_op == 2'b01) || (mem_op == 2'b10);
        case (mem_sel)
            3'b000, 3'b001, 3'b010: sel_ok = 1'b1;
            3'b100, 3'b101:         sel_ok = (mem_op == 2'b01);
            default:                sel_ok = 1'b0;
        endcase
        case (mem_sel[1:0])
            2'b01:   align_ok = ~addr[0];
            2'b10:   align_ok = (addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        rd_shift = bus_rdata >> {off_q, 3'b000};
        rd_half  = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    end

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        sel_d   = sel_q;
        off_d   = off_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        strb_d  = strb_q;
        case (state_q)
            IDLE: begin
                if (start && is_acc) begin
                    cnt_d = '0;
                    if (sel_ok && align_ok) begin
                        state_d = REQ;
                        err_d   = 1'b0;
                        st_d    = mem_op[1];
                        sel_d   = mem_sel;
                        off_d   = addr[1:0];
                        addr_d  = {addr[ADDR_W-1:2], 2'b00};
                        if (mem_op[1]) begin
                            case (mem_sel[1:0])
                                2'b00: begin
                                    strb_d  = 4'b0001 << addr[1:0];
                                    wdata_d = {4{wdata[7:0]}};
                                end
                                2'b01: begin
                                    strb_d  = 4'b0011 << addr[1:0];
                                    wdata_d = {2{wdata[15:0]}};
                                end
                                default: begin
                                    strb_d  = 4'b1111;
                                    wdata_d = wdata;
                                end
                            endcase
                        end else begin
                            strb_d  = '0;
                            wdata_d = '0;
                        end
                    end else begin
                        // Illegal request reports err without touching the bus registers.
                        state_d = RESP;
                        err_d   = 1'b1;
                    end
                end
            end
            REQ: begin
                if (bus_ack) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    if (!st_q) begin
                        case (sel_q)
                            3'b000:  rdata_d = {{24{rd_shift[7]}}, rd_shift[7:0]};
                            3'b001:  rdata_d = {{16{rd_half[15]}}, rd_half};
                            3'b100:  rdata_d = {24'd0, rd_shift[7:0]};
                            3'b101:  rdata_d = {16'd0, rd_half};
                            default: rdata_d = bus_rdata;
                        endcase
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    if ((TIMEOUT != 0) && (cnt_d == TIMEOUT)) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            st_q    <= 1'b0;
            sel_q   <= '0;
            off_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            sel_q   <= sel_d;
            off_q   <= off_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            strb_q  <= strb_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign bus_req   = (state_q == REQ);
    assign done      = (state_q == RESP) && !err_q;
    assign err       = (state_q == RESP) && err_q;
    assign bus_we    = (state_q == REQ) && st_q;
    assign bus_wstrb = (state_q == REQ) ? strb_q : 4'b0000;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a transaction-timeline model sets per-cycle
// expectations that one negedge process compares against the DUT.
module tb_mem_access_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst, start, bus_ack;
    logic [1:0]  mem_op;
    logic [2:0]  mem_sel;
    logic [31:0] addr, wdata, bus_rdata;
    logic        busy, done, err, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;

    mem_access_unit #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_op(mem_op), .mem_sel(mem_sel),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0, n_bad = 0;
    logic        chk_en = 1'b0;
    logic        e_busy, e_done, e_err, e_req, e_we;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_strb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, busy}, {31'd0, e_busy});
            check("done", {31'd0, done}, {31'd0, e_done});
            check("err", {31'd0, err}, {31'd0, e_err});
            check("bus_req", {31'd0, bus_req}, {31'd0, e_req});
            check("rdata", rdata, e_rdata);
            if (e_req) begin
                check("bus_we", {31'd0, bus_we}, {31'd0, e_we});
                check("bus_addr", bus_addr, e_addr);
                check("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, e_strb});
                if (e_we) check("bus_wdata", bus_wdata, e_wdata);
            end
        end
    end

    function automatic logic [31:0] load_val(input logic [2:0] sel, input int unsigned a, input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        case (sel)
            3'd0:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic bit legal(input logic [1:0] op, input logic [2:0] sel, input int unsigned a);
        int unsigned sz;
        if (op == 2'd1) begin
            if (!(sel == 0 || sel == 1 || sel == 2 || sel == 4 || sel == 5)) return 0;
        end else begin
            if (sel > 2) return 0;
        end
        sz = sel % 4;
        if (sz == 1 && (a % 2) != 0) return 0;
        if (sz == 2 && a != 0) return 0;
        return 1;
    endfunction

    task automatic expect_idle();
        e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_req = 1'b0;
    endtask

    // Call one tick after a rising edge with the DUT idle.
    task automatic access(input logic [1:0] op, input logic [2:0] sel, input logic [31:0] a,
                          input logic [31:0] wd, input int unsigned ack_dly, input logic [31:0] rw);
        int unsigned lo, sz;
        lo = a % 4;
        sz = sel % 4;
        start = 1'b1; mem_op = op; mem_sel = sel; addr = a; wdata = wd;
        expect_idle();
        @(posedge clk); #1;
        start = 1'b0; mem_op = 2'($urandom); mem_sel = 3'($urandom); addr = $urandom; wdata = $urandom;
        if (op == 2'd0 || op == 2'd3) begin
            @(posedge clk); #1;
            return;
        end
        e_busy = 1'b1;
        if (!legal(op, sel, lo)) begin
            e_err = 1'b1;
        end else begin
            e_req  = 1'b1;
            e_we   = (op == 2'd2);
            e_addr = a - lo;
            if (op == 2'd1) begin
                e_strb = 4'd0;
            end else if (sz == 0) begin
                e_strb  = 4'(1 << lo);
                e_wdata = (wd & 32'hFF) * 32'h01010101;
            end else if (sz == 1) begin
                e_strb  = 4'(3 << lo);
                e_wdata = (wd & 32'hFFFF) * 32'h00010001;
            end else begin
                e_strb  = 4'hF;
                e_wdata = wd;
            end
            for (int unsigned i = 0; i < TO; i++) begin
                bus_ack   = (i == ack_dly);
                bus_rdata = (i == ack_dly) ? rw : $urandom;
                @(posedge clk); #1;
                bus_ack = 1'b0; bus_rdata = $urandom;
                if (i == ack_dly) begin
                    e_req = 1'b0; e_done = 1'b1;
                    if (op == 2'd1) e_rdata = load_val(sel, lo, rw);
                    break;
                end
                if (i + 1 == TO) begin
                    e_req = 1'b0; e_err = 1'b1;
                end
            end
        end
        // A start offered during the response cycle must be ignored.
        start = 1'($urandom); mem_op = 2'd1; mem_sel = 3'd2; addr = 32'h0;
        @(posedge clk); #1;
        start = 1'b0;
        expect_idle();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
        mem_op = '0; mem_sel = '0; addr = '0; wdata = '0;
        e_we = 1'b0; e_addr = '0; e_wdata = '0; e_strb = '0; e_rdata = '0;
        expect_idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        check("rst_req_we", {30'd0, bus_req, bus_we}, 32'd0);
        check("rst_wstrb", {28'd0, bus_wstrb}, 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        access(2'd1, 3'd2, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        check("lw_lit", rdata, 32'hDEADBEEF);
        access(2'd1, 3'd0, 32'h103, 32'h0, 0, 32'h80FF0000);
        check("lb_lit", rdata, 32'hFFFFFF80);
        access(2'd1, 3'd4, 32'h103, 32'h0, 1, 32'h80FF0000);
        check("lbu_lit", rdata, 32'h00000080);
        access(2'd1, 3'd1, 32'h102, 32'h0, 0, 32'h80FF0000);
        check("lh_lit", rdata, 32'hFFFF80FF);
        access(2'd1, 3'd5, 32'h102, 32'h0, 2, 32'h80FF0000);
        check("lhu_lit", rdata, 32'h000080FF);
        access(2'd2, 3'd0, 32'h201, 32'h000000A5, 0, 32'h0);
        check("sb_rdata_kept", rdata, 32'h000080FF);
        access(2'd2, 3'd1, 32'h202, 32'h00001234, 1, 32'h0);
        access(2'd2, 3'd2, 32'h204, 32'h89ABCDEF, 0, 32'h0);
        access(2'd1, 3'd2, 32'h102, 32'h0, 0, 32'h0);
        access(2'd1, 3'd1, 32'h101, 32'h0, 0, 32'h0);
        access(2'd1, 3'd7, 32'h100, 32'h0, 0, 32'h0);
        access(2'd2, 3'd4, 32'h100, 32'h0, 0, 32'h0);
        access(2'd0, 3'd2, 32'h100, 32'h0, 0, 32'h0);
        access(2'd3, 3'd2, 32'h100, 32'h0, 0, 32'h0);
        access(2'd1, 3'd2, 32'h300, 32'h0, 3, 32'h12345678);
        check("lw_delay_lit", rdata, 32'h12345678);
        access(2'd2, 3'd2, 32'h400, 32'h55AA55AA, 9, 32'h0);
        check("timeout_rdata_kept", rdata, 32'h12345678);

        for (int k = 0; k < 200; k++) begin
            logic [1:0]  op;
            logic [31:0] a;
            int unsigned r;
            r  = $urandom % 8;
            op = (r == 0) ? 2'd0 : (r == 1) ? 2'd3 : (r < 5) ? 2'd1 : 2'd2;
            a  = $urandom;
            if ($urandom % 2 == 0) a[1:0] = 2'b00;
            access(op, 3'($urandom), a, $urandom, $urandom_range(0, 5), $urandom);
        end

        // Reset while the request is outstanding.
        start = 1'b1; mem_op = 2'd1; mem_sel = 3'd2; addr = 32'h500;
        @(posedge clk); #1;
        start = 1'b0;
        e_busy = 1'b1; e_req = 1'b1; e_we = 1'b0; e_addr = 32'h500; e_strb = 4'd0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        expect_idle();
        e_rdata = 32'd0;
        check("rst_mid_req", {31'd0, bus_req}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        access(2'd1, 3'd2, 32'h600, 32'h0, 1, 32'hCAFEF00D);
        check("post_rst_lw", rdata, 32'hCAFEF00D);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
